// File: rtl/irq_context_unit.sv
// Interrupt entry/return sequencer with the architectural PC, SP and SR.
// Pushes PC and SR on entry, vectors to VECTOR_BASE+channel, and pops SR then PC on return.
module irq_context_unit #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      NUM_IRQ     = 4,
    parameter logic [WIDTH-1:0] SP_RESET    = 'h8000,
    parameter logic [WIDTH-1:0] VECTOR_BASE = 'h0010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               boundary,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic               set_pc,
    input  logic [WIDTH-1:0]   pc_in,
    input  logic               inc_pc,
    input  logic               flags_we,
    input  logic [4:0]         flags_in,
    input  logic               ie_set,
    input  logic               ie_clr,
    input  logic               rti,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               busy,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   sp,
    output logic [WIDTH-1:0]   sr
);

    localparam int unsigned      CH_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_PC,
        S_PUSH_SR,
        S_VECTOR,
        S_POP_SR,
        S_POP_PC
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   channel;
    logic [WIDTH-1:0]  pc_q;
    logic [WIDTH-1:0]  sp_q;
    logic [WIDTH-1:0]  sr_q;

    logic              irq_any;
    logic              irq_found;
    logic [CH_W-1:0]   irq_sel;
    logic [WIDTH-1:0]  pc_idle;
    logic              accept;

    // Lowest-numbered pending channel wins.
    always_comb begin
        irq_any   = |irq_req;
        irq_found = 1'b0;
        irq_sel   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_req[i] && !irq_found) begin
                irq_sel   = CH_W'(i);
                irq_found = 1'b1;
            end
        end
    end

    always_comb begin
        pc_idle = pc_q;
        if (set_pc) begin
            pc_idle = pc_in;
        end else if (inc_pc) begin
            pc_idle = pc_q + ONE;
        end
    end

    assign accept = boundary && sr_q[WIDTH-1] && irq_any;

    // Memory outputs are registered, so each one is loaded on the transition
    // into the state that presents it, using the SP/PC/SR that state will see.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            channel   <= '0;
            pc_q      <= '0;
            sp_q      <= SP_RESET;
            sr_q      <= '0;
            irq_ack   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            irq_ack <= '0;
            case (state)
                S_IDLE: begin
                    pc_q <= pc_idle;
                    if (flags_we) begin
                        sr_q[4:0] <= flags_in;
                    end
                    if (ie_clr) begin
                        sr_q[WIDTH-1] <= 1'b0;
                    end else if (ie_set) begin
                        sr_q[WIDTH-1] <= 1'b1;
                    end
                    if (rti) begin
                        state     <= S_POP_SR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= sp_q;
                        mem_wdata <= '0;
                    end else if (accept) begin
                        state     <= S_PUSH_PC;
                        channel   <= irq_sel;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= sp_q - ONE;
                        mem_wdata <= pc_idle;
                    end
                end
                S_PUSH_PC: begin
                    if (mem_ack) begin
                        state     <= S_PUSH_SR;
                        sp_q      <= sp_q - ONE;
                        mem_addr  <= sp_q - TWO;
                        mem_wdata <= sr_q;
                    end
                end
                S_PUSH_SR: begin
                    if (mem_ack) begin
                        state     <= S_VECTOR;
                        sp_q      <= sp_q - ONE;
                        irq_ack   <= NUM_IRQ'(1) << channel;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                S_VECTOR: begin
                    state         <= S_IDLE;
                    pc_q          <= VECTOR_BASE + WIDTH'(channel);
                    sr_q[WIDTH-1] <= 1'b0;
                end
                S_POP_SR: begin
                    if (mem_ack) begin
                        state    <= S_POP_PC;
                        sr_q     <= mem_rdata;
                        sp_q     <= sp_q + ONE;
                        mem_addr <= sp_q + ONE;
                    end
                end
                S_POP_PC: begin
                    if (mem_ack) begin
                        state     <= S_IDLE;
                        pc_q      <= mem_rdata;
                        sp_q      <= sp_q + ONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign pc   = pc_q;
    assign sp   = sp_q;
    assign sr   = sr_q;

endmodule

// File: tb/tb_irq_context_unit.sv
// Scoreboard bench: expected memory transactions are queued as stimulus is driven
// and checked when the DUT's request is acknowledged; registers are checked inline.
module tb_irq_context_unit;

    logic        clock;
    logic        reset;
    logic        boundary;
    logic [3:0]  irq_req;
    logic [3:0]  irq_ack;
    logic        set_pc;
    logic [15:0] pc_in;
    logic        inc_pc;
    logic        flags_we;
    logic [4:0]  flags_in;
    logic        ie_set;
    logic        ie_clr;
    logic        rti;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] sr;

    // Second instance starting at SP=0 for the wrap-around case; always acked.
    logic [3:0]  irq_ack_w;
    logic        mem_req_w;
    logic        mem_we_w;
    logic [15:0] mem_addr_w;
    logic [15:0] mem_wdata_w;
    logic [15:0] mem_rdata_w;
    logic        busy_w;
    logic [15:0] pc_w;
    logic [15:0] sp_w;
    logic [15:0] sr_w;

    assign mem_rdata_w = (mem_addr_w == 16'hFFFE) ? 16'h8005 : 16'h0042;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } xact_t;

    xact_t       exp_q[$];
    logic [15:0] mem_model [logic [15:0]];
    int          n_cmp;
    int          n_bad;
    int unsigned ack_delay;
    int unsigned wait_cnt;

    irq_context_unit #(
        .WIDTH      (16),
        .NUM_IRQ    (4),
        .SP_RESET   (16'h8000),
        .VECTOR_BASE(16'h0010)
    ) dut (
        .clock(clock), .reset(reset), .boundary(boundary),
        .irq_req(irq_req), .irq_ack(irq_ack),
        .set_pc(set_pc), .pc_in(pc_in), .inc_pc(inc_pc),
        .flags_we(flags_we), .flags_in(flags_in),
        .ie_set(ie_set), .ie_clr(ie_clr), .rti(rti),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .pc(pc), .sp(sp), .sr(sr)
    );

    irq_context_unit #(
        .WIDTH      (16),
        .NUM_IRQ    (4),
        .SP_RESET   (16'h0000),
        .VECTOR_BASE(16'h0010)
    ) dut_w (
        .clock(clock), .reset(reset), .boundary(boundary),
        .irq_req(irq_req), .irq_ack(irq_ack_w),
        .set_pc(set_pc), .pc_in(pc_in), .inc_pc(inc_pc),
        .flags_we(flags_we), .flags_in(flags_in),
        .ie_set(ie_set), .ie_clr(ie_clr), .rti(rti),
        .mem_req(mem_req_w), .mem_we(mem_we_w), .mem_addr(mem_addr_w),
        .mem_wdata(mem_wdata_w), .mem_ack(1'b1), .mem_rdata(mem_rdata_w),
        .busy(busy_w), .pc(pc_w), .sp(sp_w), .sr(sr_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory-side scoreboard check, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got we=%b addr=%h wdata=%h, required no access", mem_we, mem_addr, mem_wdata);
            end else begin
                xact_t e;
                e = exp_q.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                    n_bad++;
                    $display("FAIL sb_xact: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
                end
            end
        end
    end

    task automatic expect_xact(input logic we, input logic [15:0] addr, input logic [15:0] data);
        xact_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory responder: acks after ack_delay idle request cycles, then advances one clock.
    task automatic tick();
        if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        boundary = 0; irq_req = '0; set_pc = 0; inc_pc = 0; flags_we = 0;
        ie_set = 0; ie_clr = 0; rti = 0; pc_in = '0; flags_in = '0;
    endtask

    task automatic test_reset();
        reset = 0; tick(); tick(); reset = 1;
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc, 16'h0000); end
        n_cmp++; if (sp !== 16'h8000) begin n_bad++; $display("FAIL rst_sp: got %h want %h", sp, 16'h8000); end
        n_cmp++; if (sr !== 16'h0000) begin n_bad++; $display("FAIL rst_sr: got %h want %h", sr, 16'h0000); end
        n_cmp++; if ({busy, mem_req, irq_ack} !== 6'b0) begin n_bad++; $display("FAIL rst_ctl: got %b want %b", {busy, mem_req, irq_ack}, 6'b0); end
    endtask

    task automatic test_idle_controls();
        set_pc = 1; inc_pc = 1; pc_in = 16'h1000; tick(); clear_ctl();
        n_cmp++; if (pc !== 16'h1000) begin n_bad++; $display("FAIL setpc_prio: got %h want %h", pc, 16'h1000); end
        inc_pc = 1; tick(); clear_ctl();
        n_cmp++; if (pc !== 16'h1001) begin n_bad++; $display("FAIL inc_pc: got %h want %h", pc, 16'h1001); end
        set_pc = 1; pc_in = 16'hFFFF; tick(); clear_ctl(); inc_pc = 1; tick(); clear_ctl();
        n_cmp++; if (pc !== 16'h0000) begin n_bad++; $display("FAIL pc_wrap: got %h want %h", pc, 16'h0000); end
        flags_we = 1; flags_in = 5'h1A; ie_set = 1; ie_clr = 1; tick(); clear_ctl();
        n_cmp++; if (sr !== 16'h001A) begin n_bad++; $display("FAIL ieclr_prio: got %h want %h", sr, 16'h001A); end
    endtask

    task automatic test_entry();
        set_pc = 1; pc_in = 16'h0123; flags_we = 1; flags_in = 5'h00; ie_set = 1; tick(); clear_ctl();
        n_cmp++; if ({pc, sr} !== {16'h0123, 16'h8000}) begin n_bad++; $display("FAIL entry_setup: got %h want %h", {pc, sr}, {16'h0123, 16'h8000}); end
        ack_delay = 0;
        expect_xact(1'b1, 16'h7FFF, 16'h0123);
        expect_xact(1'b1, 16'h7FFE, 16'h8000);
        irq_req = 4'b0110; boundary = 1; tick(); clear_ctl();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL entry_busy: got %b want %b", busy, 1'b1); end
        tick(); tick();
        n_cmp++; if (irq_ack !== 4'b0010) begin n_bad++; $display("FAIL entry_ack: got %b want %b", irq_ack, 4'b0010); end
        tick();
        n_cmp++; if ({pc, sp, sr} !== {16'h0011, 16'h7FFE, 16'h0000}) begin n_bad++; $display("FAIL entry_regs: got %h want %h", {pc, sp, sr}, {16'h0011, 16'h7FFE, 16'h0000}); end
        n_cmp++; if ({busy, irq_ack} !== 5'b0) begin n_bad++; $display("FAIL entry_done: got %b want %b", {busy, irq_ack}, 5'b0); end
    endtask

    task automatic test_return();
        mem_model[16'h7FFE] = 16'h8003;
        expect_xact(1'b0, 16'h7FFE, 16'h0000);
        expect_xact(1'b0, 16'h7FFF, 16'h0000);
        rti = 1; tick(); clear_ctl();
        tick(); tick();
        n_cmp++; if ({sr, pc, sp} !== {16'h8003, 16'h0123, 16'h8000}) begin n_bad++; $display("FAIL return_regs: got %h want %h", {sr, pc, sp}, {16'h8003, 16'h0123, 16'h8000}); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL return_busy: got %b want %b", busy, 1'b0); end
    endtask

    task automatic test_wait_states();
        ack_delay = 3;
        expect_xact(1'b1, 16'h7FFF, 16'h0123);
        expect_xact(1'b1, 16'h7FFE, 16'h8003);
        irq_req = 4'b1000; boundary = 1; tick();
        // Everything below must be ignored while the sequence runs.
        irq_req = 4'b0001; set_pc = 1; pc_in = 16'hFFFF; inc_pc = 1; flags_we = 1; flags_in = 5'h00;
        ie_clr = 1; rti = 1;
        for (int w = 0; w < 3; w++) begin
            tick();
            n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, sp} !== {2'b11, 16'h7FFF, 16'h0123, 16'h8000}) begin
                n_bad++; $display("FAIL wait_hold%0d: got %h want %h", w, {mem_req, mem_we, mem_addr, mem_wdata, sp}, {2'b11, 16'h7FFF, 16'h0123, 16'h8000});
            end
        end
        tick();
        n_cmp++; if ({sp, mem_addr, mem_wdata} !== {16'h7FFF, 16'h7FFE, 16'h8003}) begin n_bad++; $display("FAIL wait_step: got %h want %h", {sp, mem_addr, mem_wdata}, {16'h7FFF, 16'h7FFE, 16'h8003}); end
        for (int w = 0; w < 4; w++) tick();
        clear_ctl();
        n_cmp++; if (irq_ack !== 4'b1000) begin n_bad++; $display("FAIL wait_ack: got %b want %b", irq_ack, 4'b1000); end
        tick();
        n_cmp++; if ({pc, sp, sr} !== {16'h0013, 16'h7FFE, 16'h0003}) begin n_bad++; $display("FAIL wait_regs: got %h want %h", {pc, sp, sr}, {16'h0013, 16'h7FFE, 16'h0003}); end
        ack_delay = 0;
        expect_xact(1'b0, 16'h7FFE, 16'h0000);
        expect_xact(1'b0, 16'h7FFF, 16'h0000);
        rti = 1; tick(); clear_ctl(); tick(); tick();
        n_cmp++; if ({sr, pc, sp} !== {16'h8003, 16'h0123, 16'h8000}) begin n_bad++; $display("FAIL wait_restore: got %h want %h", {sr, pc, sp}, {16'h8003, 16'h0123, 16'h8000}); end
    endtask

    task automatic test_masking_priority();
        ie_clr = 1; tick(); clear_ctl();
        irq_req = 4'b1111; boundary = 1; tick(); tick();
        n_cmp++; if ({busy, mem_req, mem_we, mem_addr, mem_wdata} !== 35'b0) begin n_bad++; $display("FAIL mask_idle: got %h want %h", {busy, mem_req, mem_we, mem_addr, mem_wdata}, 35'b0); end
        clear_ctl(); ie_set = 1; tick(); clear_ctl();
        mem_model[16'h8000] = 16'h8421;
        mem_model[16'h8001] = 16'h0456;
        expect_xact(1'b0, 16'h8000, 16'h0000);
        expect_xact(1'b0, 16'h8001, 16'h0000);
        rti = 1; irq_req = 4'b1111; boundary = 1; tick(); clear_ctl();
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 16'h8000}) begin n_bad++; $display("FAIL rti_prio: got %h want %h", {mem_req, mem_we, mem_addr}, {2'b10, 16'h8000}); end
        tick(); tick();
        n_cmp++; if ({sr, pc, sp} !== {16'h8421, 16'h0456, 16'h8002}) begin n_bad++; $display("FAIL rti_regs: got %h want %h", {sr, pc, sp}, {16'h8421, 16'h0456, 16'h8002}); end
        flags_we = 1; flags_in = 5'h1A; ie_clr = 1; tick(); clear_ctl();
        n_cmp++; if (sr !== 16'h043A) begin n_bad++; $display("FAIL sr_midbits: got %h want %h", sr, 16'h043A); end
    endtask

    task automatic test_reset_mid();
        ie_set = 1; tick(); clear_ctl();
        expect_xact(1'b1, 16'h8001, 16'h0456);
        expect_xact(1'b1, 16'h8000, 16'h843A);
        irq_req = 4'b0001; boundary = 1; tick(); clear_ctl();
        tick();
        n_cmp++; if ({busy, mem_addr} !== {1'b1, 16'h8000}) begin n_bad++; $display("FAIL mid_pushsr: got %h want %h", {busy, mem_addr}, {1'b1, 16'h8000}); end
        reset = 0; tick(); reset = 1;
        n_cmp++; if ({pc, sp, sr} !== {16'h0000, 16'h8000, 16'h0000}) begin n_bad++; $display("FAIL mid_rst_regs: got %h want %h", {pc, sp, sr}, {16'h0000, 16'h8000, 16'h0000}); end
        n_cmp++; if ({busy, mem_req, irq_ack} !== 6'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got %b want %b", {busy, mem_req, irq_ack}, 6'b0); end
    endtask

    task automatic test_wrap();
        ie_set = 1; tick(); clear_ctl();
        expect_xact(1'b1, 16'h7FFF, 16'h0000);
        expect_xact(1'b1, 16'h7FFE, 16'h8000);
        irq_req = 4'b0001; boundary = 1; tick(); clear_ctl();
        n_cmp++; if ({mem_req_w, mem_addr_w, mem_wdata_w} !== {1'b1, 16'hFFFF, 16'h0000}) begin n_bad++; $display("FAIL wrap_push_pc: got %h want %h", {mem_req_w, mem_addr_w, mem_wdata_w}, {1'b1, 16'hFFFF, 16'h0000}); end
        tick();
        n_cmp++; if ({mem_addr_w, mem_wdata_w} !== {16'hFFFE, 16'h8000}) begin n_bad++; $display("FAIL wrap_push_sr: got %h want %h", {mem_addr_w, mem_wdata_w}, {16'hFFFE, 16'h8000}); end
        tick(); tick();
        n_cmp++; if ({sp_w, pc_w, sp} !== {16'hFFFE, 16'h0010, 16'h7FFE}) begin n_bad++; $display("FAIL wrap_entry: got %h want %h", {sp_w, pc_w, sp}, {16'hFFFE, 16'h0010, 16'h7FFE}); end
        expect_xact(1'b0, 16'h7FFE, 16'h0000);
        expect_xact(1'b0, 16'h7FFF, 16'h0000);
        rti = 1; tick(); clear_ctl();
        tick();
        n_cmp++; if (mem_addr_w !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_pop_addr: got %h want %h", mem_addr_w, 16'hFFFF); end
        tick();
        n_cmp++; if ({sp_w, sr_w, pc_w} !== {16'h0000, 16'h8005, 16'h0042}) begin n_bad++; $display("FAIL wrap_pop: got %h want %h", {sp_w, sr_w, pc_w}, {16'h0000, 16'h8005, 16'h0042}); end
        n_cmp++; if ({sp, sr, pc} !== {16'h8000, 16'h8000, 16'h0000}) begin n_bad++; $display("FAIL wrap_main: got %h want %h", {sp, sr, pc}, {16'h8000, 16'h8000, 16'h0000}); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; ack_delay = 0; wait_cnt = 0;
        mem_ack = 0; mem_rdata = '0; reset = 0;
        clear_ctl();
        test_reset();
        test_idle_controls();
        test_entry();
        test_return();
        test_wait_states();
        test_masking_priority();
        test_reset_mid();
        test_wrap();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
